// File: rtl/mram_bus_interface.sv
// Serial host to parallel MRAM bridge: shifts in address/data frames, drives MRAM writes and streams read data back MSB first.
// Optional build macro MRAM_WAIT_STATE_EN adds one wait cycle between load and sampling the MRAM read bus.
module mram_bus_interface (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        read_write_sel_i,
    input  logic        serial_data_in_i,
    input  logic        serial_addr_in_i,
    input  logic        data_en_i,
    input  logic        addr_en_i,
    input  logic        send_data_i,
    input  logic        load_i,
    input  logic        data_in_from_mram_en_i,
    input  logic [15:0] mram_dq_in_i,
    output logic [19:0] mram_addr_o,
    output logic [15:0] mram_dq_out_o,
    output logic        mram_dq_oe_o,
    output logic        serial_data_out_o,
    output logic        busy_o,
    output logic        frame_err_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_IN  = 3'd1,
        DRIVE_WR  = 3'd2,
        ADDR_OUT  = 3'd3,
        CAPTURE   = 3'd4,
        SHIFT_OUT = 3'd5
    } state_e;

    localparam logic [4:0] DATA_BITS = 5'd16;
    localparam logic [4:0] ADDR_BITS = 5'd20;
    localparam logic [4:0] CNT_MAX   = 5'd31;
    localparam logic [4:0] LAST_BIT  = 5'd15;

    state_e      state_q, state_d;
    logic [15:0] data_sr_q, data_sr_d;
    logic [19:0] addr_sr_q, addr_sr_d;
    logic [4:0]  dcnt_q, dcnt_d;
    logic [4:0]  acnt_q, acnt_d;
    logic [4:0]  ocnt_q, ocnt_d;
    logic [15:0] rd_sr_q, rd_sr_d;
    logic [19:0] mram_addr_q, mram_addr_d;
    logic [15:0] dq_out_q, dq_out_d;
    logic        oe_q, oe_d;
    logic        sout_q, sout_d;
    logic        busy_q, busy_d;
    logic        ferr_q, ferr_d;
    logic        wait_q, wait_d;
    logic        rw_q;
    logic        shift_ok_s;
    logic        rw_change_s;
    logic        clr_cnt_s;

    // Next-state logic for the frame FSM, shift registers, counters and outputs
    always_comb begin
        state_d     = state_q;
        data_sr_d   = data_sr_q;
        addr_sr_d   = addr_sr_q;
        dcnt_d      = dcnt_q;
        acnt_d      = acnt_q;
        ocnt_d      = ocnt_q;
        rd_sr_d     = rd_sr_q;
        mram_addr_d = mram_addr_q;
        dq_out_d    = dq_out_q;
        sout_d      = sout_q;
        ferr_d      = ferr_q;
        wait_d      = wait_q;
        clr_cnt_s   = 1'b0;
        shift_ok_s  = (state_q == IDLE) || (state_q == SHIFT_IN);
        rw_change_s = (read_write_sel_i != rw_q);

        case (state_q)
            IDLE: begin
                sout_d = 1'b0;
                ocnt_d = 5'd0;
                wait_d = 1'b0;
                if (data_en_i || addr_en_i) begin
                    state_d = SHIFT_IN;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT_IN: begin
                if (send_data_i && read_write_sel_i) begin
                    if ((dcnt_q == DATA_BITS) && (acnt_q == ADDR_BITS)) begin
                        mram_addr_d = addr_sr_q;
                        dq_out_d    = data_sr_q;
                        state_d     = DRIVE_WR;
                    end else begin
                        ferr_d    = 1'b1;
                        clr_cnt_s = 1'b1;
                        state_d   = IDLE;
                    end
                end else if (send_data_i && !load_i) begin
                    if (acnt_q == ADDR_BITS) begin
                        mram_addr_d = addr_sr_q;
                        state_d     = ADDR_OUT;
                    end else begin
                        ferr_d    = 1'b1;
                        clr_cnt_s = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    state_d = SHIFT_IN;
                end
            end
            DRIVE_WR: begin
                clr_cnt_s = 1'b1;
                state_d   = IDLE;
            end
            ADDR_OUT: begin
                if (rw_change_s) begin
                    clr_cnt_s = 1'b1;
                    state_d   = IDLE;
                end else if (load_i) begin
`ifdef MRAM_WAIT_STATE_EN
                    wait_d  = 1'b1;
`else
                    rd_sr_d = mram_dq_in_i;
`endif
                    state_d = CAPTURE;
                end else begin
                    state_d = ADDR_OUT;
                end
            end
            CAPTURE, SHIFT_OUT: begin
                if (rw_change_s || !data_in_from_mram_en_i) begin
                    sout_d    = 1'b0;
                    clr_cnt_s = 1'b1;
                    state_d   = IDLE;
                end else if (wait_q) begin
                    // Delayed capture: the MRAM bus settles one cycle after load
                    rd_sr_d = mram_dq_in_i;
                    wait_d  = 1'b0;
                end else if (send_data_i && !load_i) begin
                    sout_d  = rd_sr_q[15];
                    rd_sr_d = {rd_sr_q[14:0], 1'b0};
                    ocnt_d  = ocnt_q + 5'd1;
                    if (ocnt_q == LAST_BIT) begin
                        clr_cnt_s = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = SHIFT_OUT;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                clr_cnt_s = 1'b1;
                state_d   = IDLE;
            end
        endcase

        if (shift_ok_s && data_en_i) begin
            data_sr_d = {data_sr_q[14:0], serial_data_in_i};
            dcnt_d    = (dcnt_q == CNT_MAX) ? CNT_MAX : dcnt_q + 5'd1;
        end else begin
            data_sr_d = data_sr_d;
        end

        if (shift_ok_s && addr_en_i) begin
            addr_sr_d = {addr_sr_q[18:0], serial_addr_in_i};
            acnt_d    = (acnt_q == CNT_MAX) ? CNT_MAX : acnt_q + 5'd1;
        end else begin
            addr_sr_d = addr_sr_d;
        end

        if (clr_cnt_s) begin
            dcnt_d = 5'd0;
            acnt_d = 5'd0;
        end else begin
            dcnt_d = dcnt_d;
        end

        oe_d   = (state_d == DRIVE_WR);
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            data_sr_q   <= 16'd0;
            addr_sr_q   <= 20'd0;
            dcnt_q      <= 5'd0;
            acnt_q      <= 5'd0;
            ocnt_q      <= 5'd0;
            rd_sr_q     <= 16'd0;
            mram_addr_q <= 20'd0;
            dq_out_q    <= 16'd0;
            oe_q        <= 1'b0;
            sout_q      <= 1'b0;
            busy_q      <= 1'b0;
            ferr_q      <= 1'b0;
            wait_q      <= 1'b0;
            rw_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_sr_q   <= data_sr_d;
            addr_sr_q   <= addr_sr_d;
            dcnt_q      <= dcnt_d;
            acnt_q      <= acnt_d;
            ocnt_q      <= ocnt_d;
            rd_sr_q     <= rd_sr_d;
            mram_addr_q <= mram_addr_d;
            dq_out_q    <= dq_out_d;
            oe_q        <= oe_d;
            sout_q      <= sout_d;
            busy_q      <= busy_d;
            ferr_q      <= ferr_d;
            wait_q      <= wait_d;
            rw_q        <= read_write_sel_i;
        end
    end

    assign mram_addr_o       = mram_addr_q;
    assign mram_dq_out_o     = dq_out_q;
    assign mram_dq_oe_o      = oe_q;
    assign serial_data_out_o = sout_q;
    assign busy_o            = busy_q;
    assign frame_err_o       = ferr_q;

endmodule

// File: tb/tb_mram_bus_interface.sv
// Self-checking bench for mram_bus_interface: write/read frames, framing errors, aborts and reset against a frame-level model.
module tb_mram_bus_interface;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rw = 1'b0;
    logic        sdi = 1'b0;
    logic        sai = 1'b0;
    logic        den = 1'b0;
    logic        aen = 1'b0;
    logic        send = 1'b0;
    logic        load = 1'b0;
    logic        rden = 1'b0;
    logic [15:0] dq_in = 16'h0000;
    logic [19:0] mram_addr;
    logic [15:0] dq_out;
    logic        oe, sout, busy, ferr;

    int          checks = 0;
    int          failures = 0;
    logic [19:0] exp_addr = 20'h0;
    logic [15:0] exp_dq = 16'h0;
    logic        exp_ferr = 1'b0;

    mram_bus_interface dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .read_write_sel_i       (rw),
        .serial_data_in_i       (sdi),
        .serial_addr_in_i       (sai),
        .data_en_i              (den),
        .addr_en_i              (aen),
        .send_data_i            (send),
        .load_i                 (load),
        .data_in_from_mram_en_i (rden),
        .mram_dq_in_i           (dq_in),
        .mram_addr_o            (mram_addr),
        .mram_dq_out_o          (dq_out),
        .mram_dq_oe_o           (oe),
        .serial_data_out_o      (sout),
        .busy_o                 (busy),
        .frame_err_o            (ferr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [19:0] a, input int na, input logic [15:0] d, input int nd);
        int n;
        n = (na > nd) ? na : nd;
        for (int i = 0; i < n; i++) begin
            int ai;
            int di;
            ai  = na - 1 - i;
            di  = nd - 1 - i;
            aen = (i < na);
            den = (i < nd);
            sai = 1'b0;
            sdi = 1'b0;
            if (ai >= 0 && ai < 20) sai = a[ai];
            if (di >= 16) sdi = 1'($urandom_range(1, 0));
            else if (di >= 0) sdi = d[di];
            tick;
        end
        aen = 1'b0;
        den = 1'b0;
        sai = 1'b0;
        sdi = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        checks++;
        if ({mram_addr, dq_out, oe, sout, busy, ferr} !== 41'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {mram_addr, dq_out, oe, sout, busy, ferr});
        end
        rst_n = 1'b1;
        exp_addr = 20'h0;
        exp_dq = 16'h0;
        exp_ferr = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0 || ferr !== 1'b0) begin
            failures++;
            $display("FAIL reset_release busy=%b ferr=%b exp=0/0", busy, ferr);
        end
    endtask

    task automatic do_write(input logic [19:0] a, input logic [15:0] d, input int na, input int nd);
        rw = 1'b1;
        shift_bits(a, na, d, nd);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL wr_busy_shift got=%b exp=1", busy);
        end
        send = 1'b1;
        tick;
        send = 1'b0;
        if (na == 20 && nd == 16) begin
            exp_addr = a;
            exp_dq = d;
            checks++;
            if (mram_addr !== a || dq_out !== d || oe !== 1'b1 || ferr !== exp_ferr) begin
                failures++;
                $display("FAIL wr_drive addr=%h dq=%h oe=%b ferr=%b exp=%h %h 1 %b", mram_addr, dq_out, oe, ferr, a, d, exp_ferr);
            end
            tick;
            checks++;
            if (oe !== 1'b0 || busy !== 1'b0 || mram_addr !== a) begin
                failures++;
                $display("FAIL wr_release oe=%b busy=%b addr=%h exp=0 0 %h", oe, busy, mram_addr, a);
            end
        end else begin
            exp_ferr = 1'b1;
            checks++;
            if (ferr !== 1'b1 || oe !== 1'b0 || busy !== 1'b0 || mram_addr !== exp_addr || dq_out !== exp_dq) begin
                failures++;
                $display("FAIL wr_frame_err ferr=%b oe=%b busy=%b addr=%h dq=%h exp=1 0 0 %h %h", ferr, oe, busy, mram_addr, dq_out, exp_addr, exp_dq);
            end
            tick;
            checks++;
            if (oe !== 1'b0) begin
                failures++;
                $display("FAIL wr_err_oe got=%b exp=0", oe);
            end
        end
    endtask

    // abort: 0 none, 1 reset after 8 bits, 2 direction flip after 4 bits, 3 read enable drop after 5 bits
    task automatic do_read(input logic [19:0] a, input logic [15:0] v, input int na, input int abort);
        logic [15:0] got;
        rw = 1'b0;
        tick;
        shift_bits(a, na, 16'h0, 0);
        send = 1'b1;
        load = 1'b0;
        tick;
        send = 1'b0;
        if (na != 20) begin
            exp_ferr = 1'b1;
            checks++;
            if (ferr !== 1'b1 || busy !== 1'b0 || mram_addr !== exp_addr || oe !== 1'b0) begin
                failures++;
                $display("FAIL rd_frame_err ferr=%b busy=%b addr=%h oe=%b exp=1 0 %h 0", ferr, busy, mram_addr, oe, exp_addr);
            end
            return;
        end
        exp_addr = a;
        checks++;
        if (mram_addr !== a || oe !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rd_addr addr=%h oe=%b busy=%b exp=%h 0 1", mram_addr, oe, busy, a);
        end
        tick;
        load = 1'b1;
        rden = 1'b1;
`ifdef MRAM_WAIT_STATE_EN
        dq_in = 16'h0000;
        tick;
        load = 1'b0;
        dq_in = v;
        send = 1'b1;
        tick;
        checks++;
        if (sout !== 1'b0) begin
            failures++;
            $display("FAIL rd_wait_defer got=%b exp=0", sout);
        end
        dq_in = 16'($urandom);
`else
        dq_in = v;
        tick;
        load = 1'b0;
        dq_in = 16'($urandom);
        send = 1'b1;
`endif
        got = 16'h0;
        for (int i = 0; i < 16; i++) begin
            tick;
            got = {got[14:0], sout};
            checks++;
            if (sout !== v[15 - i] || oe !== 1'b0) begin
                failures++;
                $display("FAIL rd_bit%0d sout=%b oe=%b exp=%b 0", i, sout, oe, v[15 - i]);
            end
            if (abort == 1 && i == 7) begin
                #2 rst_n = 1'b0;
                #1;
                exp_addr = 20'h0;
                exp_dq = 16'h0;
                exp_ferr = 1'b0;
                checks++;
                if ({mram_addr, dq_out, oe, sout, busy, ferr} !== 41'd0) begin
                    failures++;
                    $display("FAIL rd_async_reset got=%h exp=0", {mram_addr, dq_out, oe, sout, busy, ferr});
                end
                tick;
                rst_n = 1'b1;
                tick;
                checks++;
                if ({mram_addr, dq_out, oe, sout, busy, ferr} !== 41'd0) begin
                    failures++;
                    $display("FAIL rd_post_reset got=%h exp=0", {mram_addr, dq_out, oe, sout, busy, ferr});
                end
                send = 1'b0;
                rden = 1'b0;
                return;
            end
            if ((abort == 2 && i == 3) || (abort == 3 && i == 4)) begin
                if (abort == 2) rw = 1'b1;
                else rden = 1'b0;
                tick;
                checks++;
                if (busy !== 1'b0 || sout !== 1'b0 || oe !== 1'b0 || ferr !== exp_ferr) begin
                    failures++;
                    $display("FAIL rd_abort%0d busy=%b sout=%b oe=%b ferr=%b exp=0 0 0 %b", abort, busy, sout, oe, ferr, exp_ferr);
                end
                send = 1'b0;
                rden = 1'b0;
                rw = 1'b0;
                return;
            end
        end
        checks++;
        if (got !== v || busy !== 1'b0) begin
            failures++;
            $display("FAIL rd_word got=%h busy=%b exp=%h 0", got, busy, v);
        end
        send = 1'b0;
        rden = 1'b0;
        tick;
        checks++;
        if (sout !== 1'b0 || oe !== 1'b0) begin
            failures++;
            $display("FAIL rd_idle sout=%b oe=%b exp=0 0", sout, oe);
        end
    endtask

    task automatic test_write;
        do_write(20'hABCDE, 16'h1234, 20, 16);
        for (int k = 0; k < 3; k++) do_write(20'($urandom), 16'($urandom), 20, 16);
    endtask

    task automatic test_read;
        do_read(20'h00010, 16'hA5C3, 20, 0);
        for (int k = 0; k < 3; k++) do_read(20'($urandom), 16'($urandom), 20, 0);
    endtask

    task automatic test_back_to_back;
        do_write(20'($urandom), 16'($urandom), 20, 16);
        do_read(20'($urandom), 16'($urandom), 20, 0);
        do_read(20'($urandom), 16'($urandom), 20, 0);
        do_write(20'($urandom), 16'($urandom), 20, 16);
    endtask

    task automatic test_aborts;
        do_read(20'($urandom), 16'($urandom), 20, 2);
        do_read(20'($urandom), 16'($urandom), 20, 3);
        do_read(20'h00010, 16'hA5C3, 20, 0);
    endtask

    task automatic test_reset_midread;
        do_read(20'($urandom), 16'hA5C3, 20, 1);
        do_read(20'h00010, 16'hA5C3, 20, 0);
    endtask

    task automatic test_frame_err;
        do_write(20'($urandom), 16'($urandom), 20, 15);
        do_write(20'($urandom), 16'($urandom), 20, 17);
        do_write(20'($urandom), 16'($urandom), 19, 16);
        do_write(20'($urandom), 16'($urandom), 20, 16);
        do_read(20'($urandom), 16'($urandom), 19, 0);
        do_read(20'($urandom), 16'($urandom), 20, 0);
        test_reset;
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_back_to_back;
        test_aborts;
        test_reset_midread;
        test_frame_err;
        test_read;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mram_bus_interface.md
MRAM_BUS_INTERFACE -- requirements
Module: mram_bus_interface

Interface
REQ-001 SHALL: clk  in  1  rising-edge clock, shared with the sequencer.
REQ-002 SHALL: rst  in  1  asynchronous, active-low reset; 0 = reset.
REQ-003 SHALL: read_write_sel  in  1  0 = read, 1 = write; sampled every cycle.
REQ-004 SHALL: serial_data_in / serial_addr_in  in  1 each  host serial bit streams, MSB first.
REQ-005 SHALL: data_en / addr_en  in  1 each  shift-enable strobes from the sequencer.
REQ-006 SHALL: send_data, load, data_in_from_MRAM_en  in  1 each  sequencer strobes.
REQ-007 SHALL: mram_dq_in  in  16  MRAM read data bus.
REQ-008 SHALL: mram_addr  out  20  registered MRAM address.
REQ-009 SHALL: mram_dq_out  out  16  registered write data.
REQ-010 SHALL: mram_dq_oe  out  1  data bus drive enable; 1 = block drives DQ.
REQ-011 SHALL: serial_data_out  out  1  read data returned to the host, MSB first.
REQ-012 SHALL: busy  out  1  high in any state other than IDLE.
REQ-013 SHALL: frame_err  out  1  sticky error flag for a malformed frame.

Function
REQ-014 SHALL: each cycle with data_en=1, shift serial_data_in into 16-bit data_sr LSB end, count data bits, saturate count at 31.
REQ-015 SHALL: each cycle with addr_en=1, shift serial_addr_in into 20-bit addr_sr, count address bits, saturate count at 31.
REQ-016 SHALL: with both enables low, hold data_sr, addr_sr and both counts unchanged.
REQ-017 SHALL: implement FSM states IDLE, SHIFT_IN, DRIVE_WR, ADDR_OUT, CAPTURE, SHIFT_OUT.
REQ-018 SHALL: transition IDLE->SHIFT_IN on the first cycle with data_en or addr_en high.
REQ-019 SHALL: on a write (read_write_sel=1, send_data=1 in SHIFT_IN) with data count=16 and address count=20, load mram_addr<=addr_sr and mram_dq_out<=data_sr, set mram_dq_oe=1 for exactly one cycle (DRIVE_WR), then go to IDLE and clear both counts.
REQ-020 SHALL: on a write with wrong counts, leave mram_addr, mram_dq_out and mram_dq_oe unchanged, set frame_err, clear counts, go to IDLE.
REQ-021 SHALL: on a read (read_write_sel=0, send_data=1, load=0 in SHIFT_IN) with address count=20, load mram_addr<=addr_sr, keep mram_dq_oe=0, go to ADDR_OUT; with address count!=20, set frame_err and go to IDLE.
REQ-022 SHALL: in ADDR_OUT with load=1, capture mram_dq_in into 16-bit rd_sr (timing per REQ-031) and go to CAPTURE.
REQ-023 SHALL: in CAPTURE/SHIFT_OUT with data_in_from_MRAM_en=1, send_data=1 and load=0, present rd_sr[15] on serial_data_out and shift rd_sr left by one with a zero fill; exactly 16 bits are emitted.
REQ-024 SHALL: return to IDLE after the 16th output bit or when data_in_from_MRAM_en falls, whichever comes first, then clear counts and drive serial_data_out=0.
REQ-025 SHALL: ignore data_en/addr_en while in ADDR_OUT, CAPTURE or SHIFT_OUT.
REQ-026 SHALL: force mram_dq_oe=0 in every state except DRIVE_WR, so the DQ bus is never contended on a read.
REQ-027 SHALL: when read_write_sel changes outside IDLE/SHIFT_IN, abort to IDLE and force mram_dq_oe=0; this does not set frame_err.

Reset
REQ-028 SHALL: when rst=0, immediately and asynchronously force: state IDLE, counts 0, data_sr/addr_sr/rd_sr 0, mram_addr 0, mram_dq_out 0, mram_dq_oe 0, serial_data_out 0, busy 0, frame_err 0.
REQ-029 SHALL: when rst=0 arrives mid-frame or mid-readout, discard the frame with no further bus activity; operation resumes on the first clk edge after rst returns to 1.
REQ-030 SHALL: clear frame_err only via reset.

Configuration
REQ-031 SHALL: with macro MRAM_WAIT_STATE_EN defined, insert one wait cycle after load=1 before sampling mram_dq_in; without it, sample mram_dq_in on the same edge that load=1 is seen.
REQ-032 SHALL: with MRAM_WAIT_STATE_EN defined, defer the first serial_data_out bit by one cycle to match the later capture.

Verification
REQ-033 SHALL: write 20-bit addr 0xABCDE and 16-bit data 0x1234, then send_data -> mram_addr=0xABCDE, mram_dq_out=0x1234, mram_dq_oe high exactly 1 cycle.
REQ-034 SHALL: read addr 0x00010 with mram_dq_in=0xA5C3 at load -> serial_data_out emits 1010010111000011 over 16 cycles and mram_dq_oe stays 0.
REQ-035 SHALL: write with only 15 data bits, then send_data -> frame_err=1, mram_dq_oe stays 0, mram_addr unchanged.
REQ-036 SHALL: drive rst=0 for 1 cycle at output bit 8 of a read -> all outputs 0 at once; next read works normally.
REQ-037 SHALL: rerun the read scenario with MRAM_WAIT_STATE_EN defined and mram_dq_in changing 0x0000->0xA5C3 one cycle after load -> output stream equals 0xA5C3.
